// File: rtl/video_timing.sv
// Raster timing generator: hsync/vsync/de plus pixel coordinates and line/frame start pulses.
// Latency: every output is registered one clk behind the hc/vc counters; frame_start is the first output cycle after reset.
// Backpressure: none. The generator free-runs after reset and has no enable or stall input.
//
// Ports:
//   clk          pixel clock (sole clock)
//   reset        synchronous active-high; driven as ~pll_lock upstream
//   hsync/vsync  sync pulses, asserted level per H_POL / V_POL
//   de           data enable, high only inside the active area
//   x, y         pixel column (11b) and line number (10b) of the current output cycle
//   line_start   1-cycle pulse at x==0 of every line
//   frame_start  1-cycle pulse at x==0, y==0
module video_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 104,
  parameter int H_BACK   = 144,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 3,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 11,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 2048) begin : g_h_total_chk
      $error("video_timing: H_TOTAL exceeds 2048, x is only 11 bits");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
      $error("video_timing: V_TOTAL exceeds 1024, y is only 10 bits");
    end
  endgenerate

  // Boundaries are held one bit wider than the counters so that a sync
  // pulse ending exactly at the total (zero back porch) cannot wrap.
  localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYN_BEG = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_SYN_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYN_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SYN_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

  logic [10:0] hc;
  logic [9:0]  vc;

  logic h_act, v_act, h_syn, v_syn;

  assign h_act = ({1'b0, hc} <  H_ACT_END);
  assign v_act = ({1'b0, vc} <  V_ACT_END);
  assign h_syn = ({1'b0, hc} >= H_SYN_BEG) && ({1'b0, hc} < H_SYN_END);
  // Depends on vc only, so vsync edges land on hc==0 (line-aligned).
  assign v_syn = ({1'b0, vc} >= V_SYN_BEG) && ({1'b0, vc} < V_SYN_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
    end else begin
      // Outputs are all decoded from the same hc/vc snapshot, so they stay
      // mutually consistent; the counters then advance one step.
      x           <= hc;
      y           <= vc;
      de          <= h_act && v_act;
      hsync       <= h_syn ? H_POL : ~H_POL;
      vsync       <= v_syn ? V_POL : ~V_POL;
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);

      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing.sv
module tb_video_timing;

  // Reduced raster for frame-level checks: 32 clk/line, 16 lines, 512 clk/frame.
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVA = 8,  SVF = 2, SVS = 3, SVB = 3;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [10:0] x;
    logic [9:0]  y;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        d_hs, d_vs, d_de, d_ls, d_fs;
  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic        n_hs, n_vs, n_de, n_ls, n_fs;
  logic [10:0] n_x;
  logic [9:0]  n_y;

  video_timing dut_d (
    .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  video_timing #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  video_timing #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_n (
    .clk(clk), .reset(reset), .hsync(n_hs), .vsync(n_vs), .de(n_de),
    .x(n_x), .y(n_y), .line_start(n_ls), .frame_start(n_fs)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  obs_t q_d[$];
  obs_t q_s[$];
  obs_t q_n[$];

  // Measurements taken from DUT outputs during the first run after reset.
  int d_de_cnt = 0, d_hs_cnt = 0, d_hs_x = -1, d_ls_last = -1, d_ls_per = -1;
  int s_fs_last = -1, s_fs_per = -1, s_de_cnt = 0, s_vs_cnt = 0, s_vs_x = -1, s_vs_y = -1;
  int n_vs_low = 0, n_hs_low = 0;

  // Expected outputs n cycles after reset release, straight from the raster
  // definition: position is n modulo line length / frame length.
  function automatic obs_t model(input int n, input int ha, input int hf, input int hs,
                                 input int hb, input int va, input int vf, input int vs,
                                 input int vb, input bit pol);
    obs_t o;
    int ht, vt, h, v;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    h    = n % ht;
    v    = (n / ht) % vt;
    o.x  = 11'(h);
    o.y  = 10'(v);
    o.de = (h < ha) && (v < va);
    o.hs = ((h >= ha + hf) && (h < ha + hf + hs)) ? pol : ~pol;
    o.vs = ((v >= va + vf) && (v < va + vf + vs)) ? pol : ~pol;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t reset_obs(input bit pol);
    obs_t o;
    o    = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    return o;
  endfunction

  function automatic obs_t get_d();
    return '{hs: d_hs, vs: d_vs, de: d_de, ls: d_ls, fs: d_fs, x: d_x, y: d_y};
  endfunction
  function automatic obs_t get_s();
    return '{hs: s_hs, vs: s_vs, de: s_de, ls: s_ls, fs: s_fs, x: s_x, y: s_y};
  endfunction
  function automatic obs_t get_n();
    return '{hs: n_hs, vs: n_vs, de: n_de, ls: n_ls, fs: n_fs, x: n_x, y: n_y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={hs,vs,de,ls,fs,x,y}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_def"}, get_d(), reset_obs(1'b1));
    check({tag, "_pos"}, get_s(), reset_obs(1'b1));
    check({tag, "_neg"}, get_n(), reset_obs(1'b0));
  endtask

  // Expected values are queued as each cycle is launched and retired when
  // that cycle's registered outputs are sampled.
  task automatic run(input int cycles, input bit measure);
    obs_t e;
    for (int i = 0; i < cycles; i++) begin
      q_d.push_back(model(i, 1024, 40, 104, 144, 600, 3, 10, 11, 1'b1));
      q_s.push_back(model(i, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1));
      q_n.push_back(model(i, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0));
      tick();
      e = q_d.pop_front();
      check("raster_def", get_d(), e);
      e = q_s.pop_front();
      check("raster_pos", get_s(), e);
      e = q_n.pop_front();
      check("raster_neg", get_n(), e);
      if (measure) begin
        if (i < 1312) begin
          if (d_de) d_de_cnt++;
          if (d_hs) begin
            d_hs_cnt++;
            if (d_hs_x < 0) d_hs_x = int'(d_x);
          end
        end
        if (d_ls) begin
          if (d_ls_last >= 0 && d_ls_per < 0) d_ls_per = i - d_ls_last;
          d_ls_last = i;
        end
        if (s_fs) begin
          if (s_fs_last >= 0 && s_fs_per < 0) s_fs_per = i - s_fs_last;
          s_fs_last = i;
        end
        if (i < 512) begin
          if (s_de) s_de_cnt++;
          if (s_vs) begin
            s_vs_cnt++;
            if (s_vs_x < 0) begin
              s_vs_x = int'(s_x);
              s_vs_y = int'(s_y);
            end
          end
          if (!n_vs) n_vs_low++;
          if (!n_hs) n_hs_low++;
        end
      end
    end
  endtask

  initial begin
    // Reset held for 5 clk: outputs must sit at reset values throughout.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_reset("reset_hold");
    end
    reset = 1'b0;

    // Two default lines and five reduced frames, including the frame wrap.
    run(2700, 1'b1);

    check_int("def_de_per_line",       d_de_cnt, 1024);
    check_int("def_hsync_width",       d_hs_cnt, 104);
    check_int("def_hsync_start_x",     d_hs_x,   1064);
    check_int("def_line_start_period", d_ls_per, 1312);
    check_int("sml_frame_period",      s_fs_per, 512);
    check_int("sml_de_per_frame",      s_de_cnt, SHA * SVA);
    check_int("sml_vsync_clks",        s_vs_cnt, SVS * (SHA + SHF + SHS + SHB));
    check_int("sml_vsync_start_x",     s_vs_x,   0);
    check_int("sml_vsync_start_y",     s_vs_y,   SVA + SVF);
    check_int("neg_vsync_low_clks",    n_vs_low, SVS * (SHA + SHF + SHS + SHB));
    check_int("neg_hsync_low_clks",    n_hs_low, SHS * (SVA + SVF + SVS + SVB));

    // Single-cycle reset mid-frame aborts the raster and restarts at 0,0.
    reset = 1'b1;
    tick();
    check_reset("reset_mid");
    reset = 1'b0;
    run(600, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
